dm_access_arbiter: RTL and testbench

//  Shares the single-port data memory between two requesters: port 0 (CPU load/store

---
 rtl/dm_access_arbiter_pkg.sv | 18 +
 rtl/dm_access_arbiter_if.sv | 50 +++++
 rtl/dm_access_arbiter_arb_rr.sv | 39 +++
 rtl/dm_access_arbiter.sv | 123 ++++++++++++
 tb/tb_dm_access_arbiter.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/dm_access_arbiter_pkg.sv
// Shared types for the data-memory access arbiter: FSM states and requester port IDs.
package dm_access_arbiter_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } state_t;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DMA = 1'b1
    } port_t;

    function automatic logic [1:0] port_onehot(input port_t p);
        return (p == PORT_DMA) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dm_access_arbiter_if.sv
// Bundle of both requester ports plus the DMEM port; slave = arbiter side, master = environment side.
interface dm_access_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              p0_req;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_adr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_gnt;
    logic              p0_rvalid;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_req;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_adr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_gnt;
    logic              p1_rvalid;
    logic [DATA_W-1:0] p1_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  p0_req, p0_we, p0_adr, p0_wdata,
        input  p1_req, p1_we, p1_adr, p1_wdata,
        input  mem_rdata,
        output p0_gnt, p0_rvalid, p0_rdata,
        output p1_gnt, p1_rvalid, p1_rdata,
        output mem_en, mem_we, mem_adr, mem_wdata,
        output busy
    );

    modport master (
        output p0_req, p0_we, p0_adr, p0_wdata,
        output p1_req, p1_we, p1_adr, p1_wdata,
        output mem_rdata,
        input  p0_gnt, p0_rvalid, p0_rdata,
        input  p1_gnt, p1_rvalid, p1_rdata,
        input  mem_en, mem_we, mem_adr, mem_wdata,
        input  busy
    );

endinterface

// File: rtl/dm_access_arbiter_arb_rr.sv
// Two-way request picker. Round-robin by default; DMARB_FIXED_PRIO_EN selects fixed port-0 priority.
module dm_arb_rr
    import dm_access_arbiter_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  port_t      last_owner,
    output logic [1:0] gnt,
    output port_t      winner,
    output logic       rr_track
);

    always_comb begin
        gnt      = '0;
        winner   = PORT_CPU;
        rr_track = 1'b0;
`ifdef DMARB_FIXED_PRIO_EN
        if (req0) begin
            winner = PORT_CPU;
        end else if (req1) begin
            winner = PORT_DMA;
        end
`else
        rr_track = 1'b1;
        // On contention the port that did not own the previous access wins.
        if (req0 && req1) begin
            winner = (last_owner == PORT_CPU) ? PORT_DMA : PORT_CPU;
        end else if (req1) begin
            winner = PORT_DMA;
        end else begin
            winner = PORT_CPU;
        end
`endif
        if (req0 || req1) begin
            gnt = port_onehot(winner);
        end
    end

endmodule

// File: rtl/dm_access_arbiter.sv
// Shares single-port DMEM between CPU (port 0) and loader/debug DMA (port 1).
// Optional build macro: DMARB_FIXED_PRIO_EN (fixed port-0 priority instead of round-robin).
module dm_access_arbiter
    import dm_access_arbiter_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                CLK,
    input  logic                RST_N,
    dm_access_arbiter_if.slave  bus
);

    state_t state_q, state_d;
    port_t  last_owner_q;
    port_t  rd_owner_q;

    logic [1:0] arb_gnt;
    port_t      winner;
    logic       rr_track;
    logic       any_req;

    logic              sel_we;
    logic [ADDR_W-1:0] sel_adr;
    logic [DATA_W-1:0] sel_wdata;

    logic              p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [DATA_W-1:0] p0_rdata, p1_rdata;
    logic              mem_en, mem_we, busy;
    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_wdata;

    assign any_req = bus.p0_req | bus.p1_req;

    dm_arb_rr u_arb (
        .req0       (bus.p0_req),
        .req1       (bus.p1_req),
        .last_owner (last_owner_q),
        .gnt        (arb_gnt),
        .winner     (winner),
        .rr_track   (rr_track)
    );

    always_comb begin
        sel_we    = (winner == PORT_DMA) ? bus.p1_we    : bus.p0_we;
        sel_adr   = (winner == PORT_DMA) ? bus.p1_adr   : bus.p0_adr;
        sel_wdata = (winner == PORT_DMA) ? bus.p1_wdata : bus.p0_wdata;
    end

    always_comb begin
        state_d   = state_q;
        p0_gnt    = 1'b0;
        p1_gnt    = 1'b0;
        p0_rvalid = 1'b0;
        p1_rvalid = 1'b0;
        p0_rdata  = '0;
        p1_rdata  = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_adr   = '0;
        mem_wdata = '0;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    p0_gnt    = arb_gnt[0];
                    p1_gnt    = arb_gnt[1];
                    mem_en    = 1'b1;
                    mem_we    = sel_we;
                    mem_adr   = sel_adr;
                    mem_wdata = sel_wdata;
                    if (!sel_we) begin
                        state_d = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                // Bubble cycle: read data returns, no new grant.
                busy = 1'b1;
                if (rd_owner_q == PORT_DMA) begin
                    p1_rvalid = 1'b1;
                    p1_rdata  = bus.mem_rdata;
                end else begin
                    p0_rvalid = 1'b1;
                    p0_rdata  = bus.mem_rdata;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_IDLE;
            last_owner_q <= PORT_DMA;
            rd_owner_q   <= PORT_CPU;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && any_req) begin
                if (rr_track) begin
                    last_owner_q <= winner;
                end
                if (!sel_we) begin
                    rd_owner_q <= winner;
                end
            end
        end
    end

    assign bus.p0_gnt    = p0_gnt;
    assign bus.p1_gnt    = p1_gnt;
    assign bus.p0_rvalid = p0_rvalid;
    assign bus.p1_rvalid = p1_rvalid;
    assign bus.p0_rdata  = p0_rdata;
    assign bus.p1_rdata  = p1_rdata;
    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_adr   = mem_adr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.busy      = busy;

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Self-checking bench for dm_access_arbiter: directed scenarios then random traffic vs. a transaction-level model.
module tb_dm_access_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
`ifdef DMARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    dm_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dm_access_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus.slave)
    );

    // Behavioural DMEM with one-cycle read latency.
    bit [DW-1:0] dmem [2**AW];
    bit [DW-1:0] rdq;
    always @(posedge CLK) begin
        if (bus.mem_en === 1'b1) begin
            if (bus.mem_we === 1'b1) dmem[bus.mem_adr] <= bus.mem_wdata;
            else                     rdq <= dmem[bus.mem_adr];
        end
    end
    assign bus.mem_rdata = rdq;

    // Reference model: expected memory image, arbitration history and pending read.
    bit [DW-1:0] ref_mem [2**AW];
    int          ref_last;
    bit          ref_busy;
    int          ref_rd_port;
    bit [DW-1:0] ref_rd_data;
    int          last_win;

    bit          req [2];
    bit          we  [2];
    logic [AW-1:0] adr [2];
    logic [DW-1:0] wd  [2];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply();
        bus.p0_req = req[0]; bus.p0_we = we[0]; bus.p0_adr = adr[0]; bus.p0_wdata = wd[0];
        bus.p1_req = req[1]; bus.p1_we = we[1]; bus.p1_adr = adr[1]; bus.p1_wdata = wd[1];
    endtask

    task automatic model_reset();
        ref_last = 1;
        ref_busy = 1'b0;
        last_win = -1;
    endtask

    task automatic set_req(input int p, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[p] = 1'b1; we[p] = w; adr[p] = a; wd[p] = d;
    endtask

    // One clock cycle: drive, check mid-cycle, advance model, move past the next rising edge.
    task automatic tick(input string tag);
        int w;
        apply();
        @(negedge CLK);
        w = -1;
        if (!ref_busy) begin
            if (req[0] && req[1]) w = FIXED ? 0 : ((ref_last == 0) ? 1 : 0);
            else if (req[0])      w = 0;
            else if (req[1])      w = 1;
        end
        chk({tag, ".busy"},   64'(bus.busy),   64'(ref_busy));
        chk({tag, ".p0_gnt"}, 64'(bus.p0_gnt), 64'(w == 0));
        chk({tag, ".p1_gnt"}, 64'(bus.p1_gnt), 64'(w == 1));
        chk({tag, ".mem_en"}, 64'(bus.mem_en), 64'(w >= 0));
        if (w >= 0) begin
            chk({tag, ".mem_we"},    64'(bus.mem_we),    64'(we[w]));
            chk({tag, ".mem_adr"},   64'(bus.mem_adr),   64'(adr[w]));
            if (we[w]) chk({tag, ".mem_wdata"}, 64'(bus.mem_wdata), 64'(wd[w]));
        end
        chk({tag, ".p0_rvalid"}, 64'(bus.p0_rvalid), 64'(ref_busy && ref_rd_port == 0));
        chk({tag, ".p1_rvalid"}, 64'(bus.p1_rvalid), 64'(ref_busy && ref_rd_port == 1));
        chk({tag, ".p0_rdata"},  64'(bus.p0_rdata),  (ref_busy && ref_rd_port == 0) ? 64'(ref_rd_data) : 64'd0);
        chk({tag, ".p1_rdata"},  64'(bus.p1_rdata),  (ref_busy && ref_rd_port == 1) ? 64'(ref_rd_data) : 64'd0);
        last_win = w;
        if (ref_busy) begin
            ref_busy = 1'b0;
        end else if (w >= 0) begin
            if (we[w]) begin
                ref_mem[adr[w]] = wd[w];
            end else begin
                ref_busy    = 1'b1;
                ref_rd_port = w;
                ref_rd_data = ref_mem[adr[w]];
            end
            if (!FIXED) ref_last = w;
        end
        @(posedge CLK);
        #1;
        if (last_win >= 0) req[last_win] = 1'b0;
    endtask

    task automatic do_reset();
        req[0] = 1'b0; req[1] = 1'b0;
        apply();
        RST_N = 1'b0;
        #1;
        chk("rst.busy",      64'(bus.busy),      64'd0);
        chk("rst.p0_gnt",    64'(bus.p0_gnt),    64'd0);
        chk("rst.p1_gnt",    64'(bus.p1_gnt),    64'd0);
        chk("rst.p0_rvalid", 64'(bus.p0_rvalid), 64'd0);
        chk("rst.p1_rvalid", 64'(bus.p1_rvalid), 64'd0);
        chk("rst.mem_en",    64'(bus.mem_en),    64'd0);
        chk("rst.mem_we",    64'(bus.mem_we),    64'd0);
        chk("rst.mem_adr",   64'(bus.mem_adr),   64'd0);
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; adr[i] = '0; wd[i] = '0;
        end
        model_reset();
        RST_N = 1'b1;
        apply();
        #2;
        do_reset();

        // Write then read back on port 0.
        set_req(0, 1'b1, 10'd5, 32'hDEADBEEF); tick("t1.wr");
        set_req(0, 1'b0, 10'd5, '0);           tick("t1.rd");
        chk("t1.busy_after_rd", 64'(bus.busy), 64'd1);
        tick("t1.rv");

        // Simultaneous reads after reset: port 0 first, bubble, then port 1.
        do_reset();
        set_req(1, 1'b1, 10'd1, 32'h1111_0001); tick("t2.w1");
        set_req(1, 1'b1, 10'd2, 32'h2222_0002); tick("t2.w2");
        do_reset();
        set_req(0, 1'b0, 10'd1, '0);
        set_req(1, 1'b0, 10'd2, '0);
        for (int i = 0; i < 4; i++) tick("t2.rd");

        // Continuous write contention for 6 cycles.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_req(0, 1'b1, AW'(20 + i), $urandom);
            set_req(1, 1'b1, AW'(40 + i), $urandom);
            tick("t3.wr");
        end
        req[0] = 1'b0; req[1] = 1'b0;
        tick("t3.drain");

        // Reset in RD_WAIT: no rvalid, busy drops at once, next contention to port 0.
        do_reset();
        set_req(1, 1'b1, 10'd7, 32'h7777_0007); tick("t4.w");
        set_req(0, 1'b0, 10'd7, '0);            tick("t4.rd");
        req[0] = 1'b0; req[1] = 1'b0; apply();
        RST_N = 1'b0;
        #1;
        chk("t4.busy",      64'(bus.busy),      64'd0);
        chk("t4.p0_rvalid", 64'(bus.p0_rvalid), 64'd0);
        chk("t4.p1_rvalid", 64'(bus.p1_rvalid), 64'd0);
        model_reset();
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        set_req(0, 1'b1, 10'd8, 32'h8);
        set_req(1, 1'b1, 10'd9, 32'h9);
        tick("t4.contend");
        chk("t4.winner", 64'(last_win), 64'd0);
        tick("t4.second");

        // Port 1 withdraws its request while port 0's read is outstanding.
        set_req(0, 1'b0, 10'd8, '0); tick("t5.rd");
        set_req(1, 1'b1, 10'd3, 32'h33); tick("t5.p1_wait");
        req[1] = 1'b0; tick("t5.idle");

        // Top address and address 0 independence.
        set_req(0, 1'b1, 10'h000, 32'h0000_AAAA); tick("t6.w0");
        set_req(1, 1'b1, 10'h3FF, 32'hCAFE_F00D); tick("t6.wtop");
        set_req(0, 1'b0, 10'h3FF, '0); tick("t6.rtop"); tick("t6.rvtop");
        set_req(1, 1'b0, 10'h000, '0); tick("t6.r0"); tick("t6.rv0");

        // Random traffic: requesters hold until granted and occasionally withdraw.
        for (int n = 0; n < 500; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!req[p]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        logic [AW-1:0] a;
                        a = ($urandom_range(0, 7) == 0) ? 10'h3FF : AW'($urandom_range(0, 15));
                        set_req(p, 1'($urandom_range(0, 1)), a, $urandom);
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    req[p] = 1'b0;
                end
            end
            tick("rnd");
        end
        req[0] = 1'b0; req[1] = 1'b0;
        tick("rnd.drain");
        tick("rnd.idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
